// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one uart_tx transmitter among numReq byte
// requesters. It grants a single byte per frame, issues a start pulse, waits for
// the transmitter's done pulse (or a watchdog timeout) and then inserts an idle gap.
module uart_tx_scheduler #(
  parameter int unsigned numReq      = 4,
  parameter int unsigned clksPerBit  = 87,
  parameter int unsigned gapBits     = 1,
  parameter int unsigned timeoutClks = 1200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [numReq-1:0]         reqValid,
  input  logic [8*numReq-1:0]       reqData,
  output logic [numReq-1:0]         reqReady,
  output logic                      txEnable,
  output logic [7:0]                txBits,
  input  logic                      txDone,
  output logic                      busy,
  output logic [$clog2(numReq)-1:0] grantIdx,
  input  logic                      errClr,
  output logic                      timeoutErr
);

  localparam int unsigned IW       = $clog2(numReq);
  localparam int unsigned GAP_CLKS = gapBits * clksPerBit;
  localparam int unsigned CNT_MAX  = (timeoutClks > GAP_CLKS) ? timeoutClks : GAP_CLKS;
  localparam int unsigned CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(timeoutClks - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'((GAP_CLKS == 0) ? 0 : GAP_CLKS - 1);
  localparam logic [IW:0]   NREQ         = (IW+1)'(numReq);
  localparam logic [IW-1:0] LAST_REQ     = IW'(numReq - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            state_q;
  logic [IW-1:0]     lastGrant_q;
  logic [IW-1:0]     grantIdx_q;
  logic [CW-1:0]     cnt_q;
  logic [numReq-1:0] reqReady_q;
  logic              txEnable_q;
  logic [7:0]        txBits_q;
  logic              busy_q;
  logic              timeoutErr_q;

  logic              found_d;
  logic [IW:0]       cand_d;
  logic [IW-1:0]     grantIdx_d;
  logic [7:0]        grantByte_d;
  logic [numReq-1:0] grantOneHot_d;

  // Round-robin search: first valid requester strictly after lastGrant, wrapping to 0
  always_comb begin
    found_d       = 1'b0;
    cand_d        = '0;
    grantIdx_d    = '0;
    grantByte_d   = '0;
    grantOneHot_d = '0;
    for (int unsigned k = 1; k <= numReq; k++) begin
      cand_d = {1'b0, lastGrant_q} + (IW+1)'(k);
      if (cand_d >= NREQ) begin
        cand_d = cand_d - NREQ;
      end
      if (!found_d && reqValid[cand_d[IW-1:0]]) begin
        found_d    = 1'b1;
        grantIdx_d = cand_d[IW-1:0];
      end
    end
    for (int unsigned i = 0; i < numReq; i++) begin
      if (grantIdx_d == IW'(i)) begin
        grantByte_d      = reqData[8*i +: 8];
        grantOneHot_d[i] = 1'b1;
      end
    end
  end

  // Frame sequencing FSM; owns every registered output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      lastGrant_q  <= LAST_REQ;
      grantIdx_q   <= '0;
      cnt_q        <= '0;
      reqReady_q   <= '0;
      txEnable_q   <= 1'b0;
      txBits_q     <= '0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      reqReady_q <= '0;
      txEnable_q <= 1'b0;
      // A watchdog set later in this block overrides the clear
      if (errClr) begin
        timeoutErr_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            txBits_q    <= grantByte_d;
            grantIdx_q  <= grantIdx_d;
            lastGrant_q <= grantIdx_d;
            reqReady_q  <= grantOneHot_d;
            txEnable_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (txDone || (cnt_q == TIMEOUT_LAST)) begin
            if (!txDone) begin
              timeoutErr_q <= 1'b1;
            end
            if (GAP_CLKS == 0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
              cnt_q   <= GAP_LOAD;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign reqReady   = reqReady_q;
  assign txEnable   = txEnable_q;
  assign txBits     = txBits_q;
  assign busy       = busy_q;
  assign grantIdx   = grantIdx_q;
  assign timeoutErr = timeoutErr_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: requesters push expected bytes into
// per-requester queues, a negedge monitor predicts grants/timing from the
// round-robin and gap/timeout rules and compares every cycle.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int CPB = 87;
  localparam int GB  = 1;
  localparam int T   = 1200;
  localparam int G   = GB * CPB;

  logic         clk;
  logic         rst;
  logic [N-1:0] reqValid;
  logic [8*N-1:0] reqData;
  logic [N-1:0] reqReady;
  logic         txEnable;
  logic [7:0]   txBits;
  logic         txDone;
  logic         busy;
  logic [1:0]   grantIdx;
  logic         errClr;
  logic         timeoutErr;

  logic [N-1:0]   b_reqValid;
  logic [8*N-1:0] b_reqData;
  logic [N-1:0]   b_reqReady;
  logic           b_txEnable;
  logic [7:0]     b_txBits;
  logic           b_txDone;
  logic           b_busy;
  logic [1:0]     b_grantIdx;
  logic           b_errClr;
  logic           b_timeoutErr;

  uart_tx_scheduler #(.numReq(N), .clksPerBit(CPB), .gapBits(GB), .timeoutClks(T)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
    .txEnable(txEnable), .txBits(txBits), .txDone(txDone), .busy(busy),
    .grantIdx(grantIdx), .errClr(errClr), .timeoutErr(timeoutErr));

  uart_tx_scheduler #(.numReq(N), .clksPerBit(CPB), .gapBits(0), .timeoutClks(T)) dut_nogap (
    .clk(clk), .rst(rst), .reqValid(b_reqValid), .reqData(b_reqData), .reqReady(b_reqReady),
    .txEnable(b_txEnable), .txBits(b_txBits), .txDone(b_txDone), .busy(b_busy),
    .grantIdx(b_grantIdx), .errClr(b_errClr), .timeoutErr(b_timeoutErr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus / scoreboard state
  logic [7:0] expq [N][$];
  int  credits [N];
  int  raise_div   = 0;
  int  tx_dmin     = 5;
  int  tx_dmax     = 20;
  int  tx_d;
  bit  tx_timeout  = 1'b0;
  bit  tx_spurious = 1'b0;
  int  frames      = 0;
  logic [7:0] nb;

  // Reference model state
  int  last_m      = N - 1;
  int  idle_from   = 0;
  int  exp_en_cyc  = -1;
  int  exp_pick    = 0;
  int  en_c        = 0;
  bit  in_wait     = 1'b0;
  bit  exp_err     = 1'b0;
  bit  exp_busy    = 1'b0;
  bit  set_err     = 1'b0;
  bit  have_bits   = 1'b0;
  logic [7:0] cur_bits = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Priority is distance after the last grant, modulo N
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = (i - last - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic bit credits_zero();
    for (int i = 0; i < N; i++) if (credits[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic present(input int i);
    credits[i]--;
    nb = 8'($urandom_range(0, 255));
    reqData[8*i +: 8] = nb;
    reqValid[i] = 1'b1;
    expq[i].push_back(nb);
  endtask

  // Requesters: reload or drop on accept, raise new bytes while credits remain
  initial begin
    for (int i = 0; i < N; i++) credits[i] = 0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (reqValid[i] && reqReady[i]) begin
          if (credits[i] > 0) present(i);
          else reqValid[i] = 1'b0;
        end else if (!reqValid[i] && credits[i] > 0 &&
                     (raise_div == 0 || $urandom_range(0, raise_div) == 0)) begin
          present(i);
        end
      end
    end
  end

  // Transmitter stand-in: done pulse after a random delay, or none plus errClr pokes
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && txEnable) begin
        if (tx_timeout) begin
          repeat (5) @(posedge clk); #1 errClr = 1'b1;
          @(posedge clk); #1 errClr = 1'b0;
          repeat (T - 6) @(posedge clk); #1 errClr = 1'b1;
          @(posedge clk); #1 errClr = 1'b0;
          repeat (19) @(posedge clk); #1 errClr = 1'b1;
          @(posedge clk); #1 errClr = 1'b0;
        end else begin
          tx_d = $urandom_range(tx_dmin, tx_dmax);
          repeat (tx_d) @(posedge clk); #1 txDone = 1'b1;
          @(posedge clk); #1 txDone = 1'b0;
          if (tx_spurious && ($urandom_range(0, 1) == 1)) begin
            repeat (2) @(posedge clk); #1 txDone = 1'b1;
            @(posedge clk); #1 txDone = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: compare the DUT against the model each cycle, then advance the model
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", 32'({reqReady, txEnable, txBits, busy, grantIdx, timeoutErr}), 32'h0);
      last_m     = N - 1;
      in_wait    = 1'b0;
      exp_en_cyc = -1;
      idle_from  = cyc + 1;
      exp_err    = 1'b0;
      have_bits  = 1'b0;
    end else begin
      exp_busy = (exp_en_cyc == cyc) || in_wait || (cyc < idle_from);
      check("ready_onehot", 32'($countones(reqReady) <= 1), 32'h1);
      if (exp_en_cyc == cyc) begin
        check("txEnable", 32'(txEnable), 32'h1);
        check("reqReady", 32'(reqReady), 32'(1 << exp_pick));
        check("grantIdx", 32'(grantIdx), 32'(exp_pick));
        if (expq[exp_pick].size() == 0) begin
          check("scoreboard_nonempty", 32'h0, 32'h1);
        end else begin
          cur_bits = expq[exp_pick].pop_front();
          check("txBits", 32'(txBits), 32'(cur_bits));
        end
        in_wait    = 1'b1;
        en_c       = cyc;
        last_m     = exp_pick;
        exp_en_cyc = -1;
        have_bits  = 1'b1;
        frames++;
      end else begin
        check("no_stray_strobe", 32'({reqReady, txEnable}), 32'h0);
        if (have_bits && (in_wait || cyc < idle_from))
          check("txBits_hold", 32'(txBits), 32'(cur_bits));
      end
      check("busy", 32'(busy), 32'(exp_busy));
      check("timeoutErr", 32'(timeoutErr), 32'(exp_err));
      set_err = 1'b0;
      if (in_wait && cyc > en_c) begin
        if (txDone) begin
          in_wait   = 1'b0;
          idle_from = cyc + G + 1;
        end else if (cyc == en_c + T) begin
          in_wait   = 1'b0;
          set_err   = 1'b1;
          idle_from = cyc + G + 1;
        end
      end
      if (set_err) exp_err = 1'b1;
      else if (errClr) exp_err = 1'b0;
      if (exp_en_cyc < 0 && !in_wait && cyc >= idle_from && reqValid != '0) begin
        exp_pick   = rr_pick(reqValid, last_m);
        exp_en_cyc = cyc + 1;
        idle_from  = 32'h7fff_ffff;
      end
    end
  end

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while (k < maxc && !(credits_zero() && reqValid == '0 && !busy && exp_en_cyc < 0)) begin
      @(posedge clk); #4;
      k++;
    end
    checks++;
    if (k >= maxc) begin
      failures++;
      $display("FAIL drain_timeout: busy=%0b after %0d cycles, required idle", busy, maxc);
    end
    repeat (2) @(posedge clk);
  endtask

  // Directed run on the zero-gap instance
  initial begin
    b_reqValid = '0; b_reqData = '0; b_txDone = 1'b0; b_errClr = 1'b0;
    repeat (6) @(posedge clk); #2;
    b_reqData[7:0] = 8'h3C; b_reqValid[0] = 1'b1;
    @(negedge clk); check("gap0_idle_busy", 32'(b_busy), 32'h0);
    @(negedge clk);
    check("gap0_enable", 32'(b_txEnable), 32'h1);
    check("gap0_ready", 32'(b_reqReady), 32'h1);
    check("gap0_bits", 32'(b_txBits), 32'h3C);
    @(posedge clk); #2;
    b_reqValid[0] = 1'b0; b_reqData[15:8] = 8'h96; b_reqValid[1] = 1'b1;
    repeat (3) @(posedge clk); #1 b_txDone = 1'b1;
    @(negedge clk); check("gap0_wait_busy", 32'(b_busy), 32'h1);
    @(posedge clk); #1 b_txDone = 1'b0;
    @(negedge clk); check("gap0_idle_after_done", 32'({b_busy, b_txEnable}), 32'h0);
    @(negedge clk);
    check("gap0_next_enable", 32'(b_txEnable), 32'h1);
    check("gap0_next_grant", 32'(b_grantIdx), 32'h1);
    check("gap0_next_ready", 32'(b_reqReady), 32'h2);
    check("gap0_next_bits", 32'(b_txBits), 32'h96);
    @(posedge clk); #2 b_reqValid[1] = 1'b0;
    repeat (4) @(posedge clk); #1 b_txDone = 1'b1;
    @(posedge clk); #1 b_txDone = 1'b0;
    @(negedge clk); check("gap0_final_idle", 32'(b_busy), 32'h0);
  end

  // Phase sequencing
  initial begin
    int f0;
    int k;
    rst = 1'b0; reqValid = '0; reqData = '0; txDone = 1'b0; errClr = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk); #3 rst = 1'b0;

    // Single request from requester 1
    @(posedge clk); #2;
    reqData[15:8] = 8'hA5; reqValid[1] = 1'b1; expq[1].push_back(8'hA5);
    drain(400);

    // All four continuously after a fresh reset
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #2;
    raise_div = 0;
    for (int i = 0; i < N; i++) credits[i] = 2;
    drain(3000);

    // Wrap search: req3 then req2 alone
    @(posedge clk); #2 credits[3] = 1;
    drain(400);
    @(posedge clk); #2 credits[2] = 1;
    drain(400);

    // Watchdog with errClr coincident with the timeout
    tx_timeout = 1'b1;
    @(posedge clk); #2 credits[0] = 1;
    drain(3000);
    tx_timeout = 1'b0;

    // Reset while waiting for done; stale done must be ignored
    tx_dmin = 60; tx_dmax = 60;
    f0 = frames;
    @(posedge clk); #2 credits[1] = 1;
    k = 0;
    while (k < 200 && frames == f0) begin
      @(posedge clk);
      k++;
    end
    check("frame_started", 32'(frames != f0), 32'h1);
    repeat (20) @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_bits", 32'(txBits), 32'h0);
    check("async_rst_strobes", 32'({reqReady, txEnable}), 32'h0);
    repeat (10) @(posedge clk); #3 rst = 1'b0;
    repeat (60) @(posedge clk);
    tx_dmin = 5; tx_dmax = 30;
    #2;
    for (int i = 0; i < N; i++) credits[i] = 1;
    k = 0;
    while (k < 50 && !txEnable) begin
      @(negedge clk);
      k++;
    end
    check("prio_after_reset", 32'({txEnable, grantIdx}), 32'h4);
    drain(3000);

    // Randomised traffic with spurious done pulses during the gap
    tx_spurious = 1'b1;
    tx_dmin = 1; tx_dmax = 40;
    raise_div = 3;
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #2;
      for (int i = 0; i < N; i++) credits[i] = $urandom_range(0, 2);
      if (credits_zero()) credits[r % N] = 1;
      drain(4000);
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    failures++;
    $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
